// File: rtl/traffic_light_monitor.sv
// Receiving-end monitor for the highway/country light codes: checks legality,
// conflicts, colour order and dwell times, latches the first fault, counts country cycles.
module traffic_light_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MIN_ALLRED = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  input  logic       enable,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_mode,
  output logic [7:0] cycle_count
);

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BADC   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MIN_AR_C  = CNT_W'(MIN_ALLRED);

  logic [1:0]       prev_h_q, prev_h_d;
  logic [1:0]       prev_c_q, prev_c_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] yel_h_q, yel_h_d;
  logic [CNT_W-1:0] yel_c_q, yel_c_d;
  logic [CNT_W-1:0] allred_q, allred_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic [7:0]       cycle_q, cycle_d;

  logic             illegal_s;
  logic             conflict_s;
  logic             clear_ok_s;
  logic             restart_s;
  logic [2:0]       viol_h_s;
  logic [2:0]       viol_c_s;
  logic [2:0]       viol_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  function automatic logic [CNT_W-1:0] yel_next(input logic [1:0] prev, input logic [1:0] cur,
                                                input logic [CNT_W-1:0] cnt, input logic restart);
    if (cur != YELLOW) begin
      return '0;
    end else if (restart || (prev != YELLOW)) begin
      return CNT_ONE;
    end else begin
      return sat_inc(cnt);
    end
  endfunction

  // Transition verdict for one road; checks 3..6 in priority order.
  function automatic logic [2:0] road_viol(input logic [1:0] prev, input logic [1:0] cur,
                                           input logic [CNT_W-1:0] ycnt, input logic [CNT_W-1:0] arcnt);
    if ((prev == GREEN) && (cur == RED)) begin
      return 3'd3;
    end else if (((prev == YELLOW) && (cur == GREEN)) || ((prev == RED) && (cur == YELLOW))) begin
      return 3'd4;
    end else if ((prev == YELLOW) && (cur == RED) && (ycnt < MIN_Y_C)) begin
      return 3'd5;
    end else if ((prev == RED) && (cur == GREEN) && (arcnt < MIN_AR_C)) begin
      return 3'd6;
    end else begin
      return 3'd0;
    end
  endfunction

  function automatic logic [2:0] min_nz(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0) begin
      return b;
    end else if ((b == 3'd0) || (a < b)) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Sample classification and violation selection.
  always_comb begin
    illegal_s  = (hwy == BADC) || (cntry == BADC);
    conflict_s = (hwy != RED) && (cntry != RED);
    clear_ok_s = fault_q && clear_fault && !illegal_s && !conflict_s;
    restart_s  = !primed_q || clear_ok_s;
    viol_h_s   = road_viol(prev_h_q, hwy, yel_h_q, allred_q);
    viol_c_s   = road_viol(prev_c_q, cntry, yel_c_q, allred_q);
    if (illegal_s) begin
      viol_s = 3'd1;
    end else if (conflict_s) begin
      viol_s = 3'd2;
    end else if (!restart_s) begin
      viol_s = min_nz(viol_h_s, viol_c_s);
    end else begin
      viol_s = 3'd0;
    end
  end

  // Next-state: tracking registers, dwell counters, fault latch and cycle counter.
  always_comb begin
    prev_h_d = hwy;
    prev_c_d = cntry;
    primed_d = 1'b1;
    yel_h_d  = yel_next(prev_h_q, hwy, yel_h_q, restart_s);
    yel_c_d  = yel_next(prev_c_q, cntry, yel_c_q, restart_s);
    if ((hwy == RED) && (cntry == RED)) begin
      allred_d = restart_s ? CNT_ONE : sat_inc(allred_q);
    end else begin
      allred_d = '0;
    end
    fault_d = fault_q;
    code_d  = code_q;
    if (!fault_q) begin
      if (enable && (viol_s != 3'd0)) begin
        fault_d = 1'b1;
        code_d  = viol_s;
      end else begin
        fault_d = 1'b0;
        code_d  = code_q;
      end
    end else if (clear_ok_s) begin
      fault_d = 1'b0;
      code_d  = 3'd0;
    end else begin
      fault_d = 1'b1;
      code_d  = code_q;
    end
    // A country cycle completes on a clean YELLOW->RED, judged even when checks are disarmed.
    if (!restart_s && (viol_s == 3'd0) && (prev_c_q == YELLOW) && (cntry == RED)) begin
      cycle_d = cycle_q + 8'd1;
    end else begin
      cycle_d = cycle_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_h_q <= RED;
      prev_c_q <= RED;
      primed_q <= 1'b0;
      yel_h_q  <= '0;
      yel_c_q  <= '0;
      allred_q <= '0;
      fault_q  <= 1'b0;
      code_q   <= 3'd0;
      cycle_q  <= 8'd0;
    end else begin
      prev_h_q <= prev_h_d;
      prev_c_q <= prev_c_d;
      primed_q <= primed_d;
      yel_h_q  <= yel_h_d;
      yel_c_q  <= yel_c_d;
      allred_q <= allred_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      cycle_q  <= cycle_d;
    end
  end

  assign fault       = fault_q;
  assign flash_mode  = fault_q;
  assign fault_code  = code_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed and randomized bench for traffic_light_monitor against a sample-history reference model.
module tb_traffic_light_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       enable;
  logic       clear_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_mode;
  logic [7:0] cycle_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: light history since the last (re)start.
  int q_h[$];
  int q_c[$];
  bit m_fault;
  int m_code;
  int m_cycle;

  always #5 clock = ~clock;

  traffic_light_monitor dut (
    .clock       (clock),
    .reset       (reset),
    .hwy         (hwy),
    .cntry       (cntry),
    .enable      (enable),
    .clear_fault (clear_fault),
    .fault       (fault),
    .fault_code  (fault_code),
    .flash_mode  (flash_mode),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int yel_dwell(input bit road_c);
    int n = 0;
    for (int i = q_h.size() - 1; i >= 0; i--) begin
      if ((road_c ? q_c[i] : q_h[i]) != 1) break;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int allred_dwell();
    int n = 0;
    for (int i = q_h.size() - 1; i >= 0; i--) begin
      if (q_h[i] != 0 || q_c[i] != 0) break;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  // Colour codes: 0 red, 1 yellow, 2 green.
  function automatic int road_err(input int p, input int c, input int yd, input int ar);
    if (p == 2 && c == 0) return 3;
    if ((p == 1 && c == 2) || (p == 0 && c == 1)) return 4;
    if (p == 1 && c == 0 && yd < 3) return 5;
    if (p == 0 && c == 2 && ar < 2) return 6;
    return 0;
  endfunction

  task automatic model_reset();
    m_fault = 0;
    m_code  = 0;
    m_cycle = 0;
    q_h.delete();
    q_c.delete();
  endtask

  task automatic model_step(input int h, input int c, input bit en, input bit clr);
    int v = 0;
    int eh;
    int ec;
    bit primed = (q_h.size() > 0);
    bit clr_ok;
    if (h == 3 || c == 3) v = 1;
    else if (h != 0 && c != 0) v = 2;
    clr_ok = m_fault && clr && (v == 0);
    if (v == 0 && primed && !clr_ok) begin
      eh = road_err(q_h[$], h, yel_dwell(0), allred_dwell());
      ec = road_err(q_c[$], c, yel_dwell(1), allred_dwell());
      if (eh == 0) v = ec;
      else if (ec == 0) v = eh;
      else v = (eh < ec) ? eh : ec;
    end
    if (primed && !clr_ok && v == 0 && q_c[$] == 1 && c == 0) m_cycle = (m_cycle + 1) % 256;
    if (!m_fault) begin
      if (en && v != 0) begin
        m_fault = 1;
        m_code  = v;
      end
    end else if (clr_ok) begin
      m_fault = 0;
      m_code  = 0;
      q_h.delete();
      q_c.delete();
    end
    q_h.push_back(h);
    q_c.push_back(c);
    if (q_h.size() > 300) begin
      void'(q_h.pop_front());
      void'(q_c.pop_front());
    end
  endtask

  task automatic check_model();
    chk("fault", fault, m_fault);
    chk("fault_code", fault_code, m_code);
    chk("flash_mode", flash_mode, m_fault);
    chk("cycle_count", cycle_count, m_cycle);
  endtask

  task automatic step(input logic [1:0] h, input logic [1:0] c, input bit en = 1'b1, input bit clr = 1'b0);
    hwy = h;
    cntry = c;
    enable = en;
    clear_fault = clr;
    @(posedge clock);
    model_step(int'(h), int'(c), en, clr);
    #1;
    check_model();
    @(negedge clock);
  endtask

  task automatic hold(input logic [1:0] h, input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) step(h, c);
  endtask

  task automatic expect_out(input string tag, input bit f, input int code);
    chk({tag, "_fault"}, fault, f);
    chk({tag, "_code"}, fault_code, code);
    chk({tag, "_flash"}, flash_mode, f);
  endtask

  initial begin
    logic [1:0] rh;
    logic [1:0] rc;
    int r;
    reset = 1'b0;
    hwy = 2'd0;
    cntry = 2'd0;
    enable = 1'b1;
    clear_fault = 1'b0;
    model_reset();
    #12;
    expect_out("reset", 1'b0, 0);
    chk("reset_cycle", cycle_count, 0);
    @(negedge clock);
    reset = 1'b1;

    // Legal service cycle
    hold(2'd2, 2'd0, 5);
    hold(2'd1, 2'd0, 3);
    hold(2'd0, 2'd0, 2);
    hold(2'd0, 2'd2, 4);
    hold(2'd0, 2'd1, 3);
    chk("legal_cycle_pre", cycle_count, 0);
    step(2'd0, 2'd0);
    chk("legal_cycle_post", cycle_count, 1);
    step(2'd0, 2'd0);
    step(2'd2, 2'd0);
    expect_out("legal", 1'b0, 0);

    // Conflict, later illegal code does not overwrite
    step(2'd2, 2'd2);
    expect_out("conflict", 1'b1, 2);
    step(2'd3, 2'd0);
    expect_out("conflict_keep", 1'b1, 2);
    step(2'd2, 2'd2, 1'b1, 1'b1);
    expect_out("clear_blocked", 1'b1, 2);
    step(2'd0, 2'd0, 1'b1, 1'b1);
    expect_out("clear_ok", 1'b0, 0);

    // Skipped yellow
    step(2'd0, 2'd0);
    step(2'd2, 2'd0);
    step(2'd0, 2'd0);
    expect_out("skip_yellow", 1'b1, 3);
    step(2'd0, 2'd0, 1'b1, 1'b1);

    // Short yellow
    step(2'd0, 2'd0);
    step(2'd2, 2'd0);
    hold(2'd1, 2'd0, 2);
    step(2'd0, 2'd0);
    expect_out("short_yellow", 1'b1, 5);
    step(2'd0, 2'd0, 1'b1, 1'b1);

    // Short all-red
    step(2'd0, 2'd0);
    step(2'd2, 2'd0);
    hold(2'd1, 2'd0, 3);
    step(2'd0, 2'd0);
    expect_out("yellow_min_ok", 1'b0, 0);
    step(2'd0, 2'd2);
    expect_out("short_allred", 1'b1, 6);
    step(2'd0, 2'd0, 1'b1, 1'b1);

    // Priority and bad sequence
    step(2'd3, 2'd2);
    expect_out("priority", 1'b1, 1);
    step(2'd0, 2'd0, 1'b1, 1'b1);
    step(2'd0, 2'd0);
    step(2'd2, 2'd0);
    step(2'd1, 2'd0);
    step(2'd2, 2'd0);
    expect_out("bad_seq", 1'b1, 4);
    step(2'd0, 2'd0, 1'b1, 1'b1);

    // Disarmed skip
    step(2'd0, 2'd0);
    step(2'd2, 2'd0);
    step(2'd0, 2'd0, 1'b0, 1'b0);
    expect_out("disabled", 1'b0, 0);

    // Asynchronous reset between edges, mid-yellow with a fault latched
    step(2'd0, 2'd0);
    step(2'd2, 2'd0);
    step(2'd1, 2'd0);
    step(2'd1, 2'd1);
    expect_out("pre_reset", 1'b1, 2);
    chk("pre_reset_cycle", cycle_count, 1);
    #3;
    reset = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 0);
    chk("async_reset_cycle", cycle_count, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(2'd2, 2'd0);
    expect_out("first_sample", 1'b0, 0);

    // 256 legal country cycles wrap the counter
    for (int i = 0; i < 256; i++) begin
      hold(2'd1, 2'd0, 3);
      hold(2'd0, 2'd0, 2);
      step(2'd0, 2'd2);
      hold(2'd0, 2'd1, 3);
      hold(2'd0, 2'd0, 2);
      step(2'd2, 2'd0);
      if (i == 127) chk("wrap_mid", cycle_count, 128);
    end
    chk("wrap", cycle_count, 0);
    expect_out("wrap", 1'b0, 0);

    // Randomized traffic against the model
    rh = 2'd2;
    rc = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55) begin
        rh = rh;
      end else if (r < 75) begin
        rh = 2'($urandom_range(0, 2));
      end else if (r < 95) begin
        rc = 2'($urandom_range(0, 2));
      end else begin
        rh = 2'($urandom_range(0, 3));
        rc = 2'($urandom_range(0, 3));
      end
      step(rh, rc, ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Conflict/sequence monitor on the controller's light outputs, i.e. the receiving end of the hwy/cntry light-code interface.
- Samples both 2-bit light codes every clock and checks code legality, cross-road conflicts, the per-road colour sequence and minimum yellow and all-red dwell times.
- Latches the first violation with a code and raises flash_mode so the cabinet can force flashing red.
- Counts completed country-road service cycles.

Parameters:
- MIN_YELLOW, 3, minimum consecutive samples a road must show YELLOW before RED.
- MIN_ALLRED, 2, minimum consecutive both-RED samples before either road goes GREEN.
- CNT_W, 8, width of the dwell counters; they saturate at 2^CNT_W-1.

Ports:
- clock  input  1  system clock; all sampling on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- hwy  input  2  highway light code: RED=0, YELLOW=1, GREEN=2, 3 illegal.
- cntry  input  2  country light code, same encoding.
- enable  input  1  1 = checks armed; 0 = tracking only, no new faults.
- clear_fault  input  1  synchronous request to clear a latched fault.
- fault  output  1  latched violation flag.
- fault_code  output  3  code of the first latched violation; 0 = none.
- flash_mode  output  1  request for flashing red; equals fault.
- cycle_count  output  8  completed country cycles; wraps 255->0.

Behaviour:
- Reset (reset=0, async): fault=0, fault_code=0, flash_mode=0, cycle_count=0, dwell counters=0, primed=0, previous-sample registers=RED/RED.
- Every posedge samples hwy and cntry.
  - Registered outputs update at the same edge that samples a violation, so there is 1 cycle of latency from stable inputs.
- First edge after reset release (primed=0):
  - Load the previous-sample registers and set primed=1.
  - Only checks 1 and 2 apply; no transition, dwell or count checks.
- Checks per sample, numbered in priority order (lowest number wins when several fire in the same cycle):
  - 1 ILLEGAL_CODE: either code is 3.
  - 2 CONFLICT: both roads non-RED.
  - 3 SKIP_YELLOW: a road goes GREEN->RED directly.
  - 4 BAD_SEQ: a road goes YELLOW->GREEN or RED->YELLOW.
  - 5 SHORT_YELLOW: a road goes YELLOW->RED with yellow dwell < MIN_YELLOW. Yellow dwell is the count of consecutive prior samples at YELLOW, the first one included.
  - 6 SHORT_ALLRED: a road goes RED->GREEN while the both-RED counter (value from the previous sample) < MIN_ALLRED.
  - Legal per-road sequence: GREEN->YELLOW->RED->GREEN. Holding the same colour is always legal.
- Fault latch:
  - The first violation with enable=1 sets fault=1 and fault_code to that violation's number.
  - Later violations do not change fault_code.
  - With enable=0, violations are ignored, but the previous-sample registers and counters keep tracking.
- clear_fault=1 at an edge while fault=1:
  - If the current sample has no check-1/2 violation: fault=0 and fault_code=0, and the previous-sample registers and dwell counters reload from the current sample, so no transition is judged across the clear.
  - Otherwise the fault stays latched with its original code.
- Edge cases for clear_fault:
  - With fault=0, clear_fault has no effect.
  - Simultaneous clear and new violation: the fault stays latched; fault_code is the pre-existing code if one was latched.
- Counters:
  - The per-road yellow dwell counter resets to 1 on entering YELLOW, increments while YELLOW, saturates, and clears on leaving.
  - The both-RED counter increments on both-RED samples, saturates, and clears otherwise.
- cycle_count increments on a cntry YELLOW->RED transition that raises no violation, regardless of enable; it wraps.
- Reset asserted mid-operation returns all state to reset values immediately (async), with no clock required.

Test Plan:
- Legal cycle (release reset; hwy/cntry = G/R x5, Y/R x3, R/R x2, R/G x4, R/Y x3, R/R x2, G/R) -> fault=0 throughout; cycle_count goes 0->1 on the R/Y->R/R sample.
- Conflict (hwy=2, cntry=2 sampled while enabled) -> fault=1 and flash_mode=1 after that edge, fault_code=2. A following hwy=3 leaves fault_code=2.
- Sequence errors:
  - hwy G->R directly -> fault_code=3.
  - After a clear, with hwy=Y held 2 samples then R -> fault_code=5.
  - cntry R->G after 1 both-RED sample -> fault_code=6.
- Priority (single sample with hwy=3 and cntry=2 from clean state) -> fault_code=1. A G->Y->G sequence -> fault_code=4.
- Enable/clear:
  - enable=0 during a G->R skip -> no fault.
  - clear_fault while hwy=cntry=2 -> fault stays 1.
  - clear_fault with a legal R/R sample -> fault=0 and fault_code=0 next cycle.
- Async reset (pull reset low mid-yellow, between edges) -> all outputs 0 immediately. After release, the first sample G/R is not judged as a transition.
- Wrap: 256 legal country cycles -> cycle_count returns to 0.
